pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port next_pc  input  16  redirect target from the downstream 2:1 PC-select mux output.
REQ-005 SHALL have port pc_load  input  1  take next_pc instead of sequential increment.
REQ-006 SHALL have port stall  input  1  pipeline hold request.
REQ-007 SHALL have port pc_plus2  output  16  combinational pc+2; drives the sequential input of the PC-select mux.
REQ-008 SHALL have ports imem_req  output  1, and imem_addr  output  16, for the fetch request and its address.
REQ-009 SHALL have ports imem_ack  input  1, and imem_rdata  input  16, for the fetch response and its data.
REQ-010 SHALL have ports instr_valid  output  1, instr  output  16, and instr_pc  output  16, for the fetched-instruction slot.
REQ-011 SHALL have port instr_ready  input  1  consumer accepts instr.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, and HOLD.
REQ-013 SHALL transition IDLE -> FETCH unconditionally on the first clock after rst_n deasserts.
REQ-014 In FETCH, SHALL assert imem_req=1 and drive imem_addr=pc, holding both until imem_ack.
REQ-015 On FETCH with imem_ack=1 and pc_load=0, SHALL register instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+2, and transition -> HOLD.
REQ-016 In HOLD, SHALL keep imem_req=0 and hold instr, instr_pc, and instr_valid stable.
REQ-017 In HOLD with instr_ready=1 and stall=0, SHALL set instr_valid<=0 and transition -> FETCH (one-cycle bubble).
REQ-018 SHALL compute pc_plus2 modulo 2^16 (16'hFFFE -> 16'h0000); all PC arithmetic SHALL wrap with no overflow flag.
REQ-019 With pc_load=1 and stall=0 in any non-IDLE state, SHALL set pc<=next_pc and then be in FETCH next cycle.
REQ-020 With pc_load and imem_ack in the same FETCH cycle, SHALL discard imem_rdata, leave instr_valid unchanged, and not increment pc; pc_load wins.
REQ-021 With pc_load in HOLD, SHALL flush the slot (instr_valid<=0) regardless of instr_ready.
REQ-022 While stall=1, SHALL ignore pc_load, block the HOLD exit, and still capture an imem_ack in FETCH (FETCH -> HOLD allowed).
REQ-023 In IDLE, SHALL ignore pc_load.

Reset
REQ-024 On rst_n=0, SHALL immediately set pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, and instr_pc=0.
REQ-025 While in reset, SHALL drive imem_addr=RESET_PC and pc_plus2=RESET_PC+2.
REQ-026 Reset asserted mid-fetch SHALL abandon the request; a late imem_ack after reset SHALL be ignored unless in FETCH.

Configuration
REQ-027 Macro PC_ALIGN_CHECK_EN SHALL select alignment checking.
REQ-028 With PC_ALIGN_CHECK_EN defined, SHALL add port misalign_err  output  1, reset 0.
REQ-029 With PC_ALIGN_CHECK_EN defined and a redirect accepted per REQ-019 where next_pc[0]=1: SHALL pulse misalign_err for one cycle, keep pc unchanged, and not flush the slot.
REQ-030 Without PC_ALIGN_CHECK_EN, SHALL omit misalign_err, force next_pc[0] to 0 on load, and otherwise follow REQ-019.

Verification
REQ-031 Bench SHALL cover: RESET_PC=16'h0100, release reset, ack each fetch after 1 cycle, instr_ready=1 -> imem_addr sequence 0100, 0102, 0104; instr_pc matches each address.
REQ-032 Bench SHALL cover: pc=16'hFFFE, ack -> instr_pc=FFFE, next imem_addr=0000, pc_plus2 transitions 0000 -> 0002.
REQ-033 Bench SHALL cover: FETCH at 0040, pc_load=1 with next_pc=0200 in the same cycle as imem_ack -> no instr_valid, next imem_addr=0200.
REQ-034 Bench SHALL cover: HOLD with instr_ready=1 and stall=1 for 3 cycles -> instr_valid stays 1, instr constant, imem_req=0; stall drop -> FETCH next cycle.
REQ-035 Bench SHALL cover: rst_n pulsed low while imem_req=1 at 0080 -> same-cycle imem_req=0 and instr_valid=0; after release, fetch restarts at RESET_PC.
REQ-036 Bench SHALL cover, with PC_ALIGN_CHECK_EN: next_pc=0201 with pc_load=1 -> misalign_err=1 for one cycle, pc unchanged. Without PC_ALIGN_CHECK_EN: same stimulus -> next imem_addr=0200.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: one outstanding instruction fetch, a single-entry output slot and PC redirects.
// Optional macro PC_ALIGN_CHECK_EN: reject odd redirect targets and flag them on misalign_err.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] next_pc,
    input  logic        pc_load,
    input  logic        stall,
    output logic [15:0] pc_plus2,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
`ifdef PC_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    input  logic        instr_ready
);

    // state | meaning
    // IDLE  | leaving reset, one cycle before the first fetch
    // FETCH | request outstanding at pc, waiting for imem_ack
    // HOLD  | fetched instruction held in the slot until consumed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] instr_nxt, instr_pc_nxt;
    logic        instr_valid_nxt;
    logic        redirect;
    logic        bad_target;
    logic        misalign_nxt;
    logic [15:0] load_target;

`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_q;
    assign bad_target  = next_pc[0];
    assign load_target = next_pc;
`else
    logic        unused_next_pc_lsb;
    assign unused_next_pc_lsb = next_pc[0];
    assign bad_target  = 1'b0;
    assign load_target = {next_pc[15:1], 1'b0};
`endif

    assign redirect  = pc_load && !stall;
    assign pc_plus2  = pc + 16'd2;
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= misalign_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        misalign_nxt    = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                // A redirect beats a simultaneous ack: the returned word belongs to the old path.
                if (redirect) begin
                    misalign_nxt = bad_target;
                    if (!bad_target) begin
                        pc_nxt = load_target;
                    end
                end else if (imem_ack) begin
                    instr_nxt       = imem_rdata;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    pc_nxt          = pc_plus2;
                    state_nxt       = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    misalign_nxt = bad_target;
                    // A rejected odd target leaves the slot and pc untouched.
                    if (!bad_target) begin
                        pc_nxt          = load_target;
                        instr_valid_nxt = 1'b0;
                        state_nxt       = FETCH;
                    end
                end else if (instr_ready && !stall) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_nxt;
`endif

endmodule
